// File: rtl/readout_sequencer_pkg.sv
// Shared constants and types for the PSEC5 readout sequencer: channel geometry,
// FSM state encoding, mode-bit positions and the SPI register map.
package psec5_pkg;

    localparam int NUM_CH   = 8;
    localparam int CH_WIDTH = 50;
    localparam int CH_IDX_W = $clog2(NUM_CH);

    localparam int MODE_TRIG_SRC   = 0;
    localparam int MODE_CONTINUOUS = 1;

    localparam logic [7:0] ADDR_TCM     = 8'd1;
    localparam logic [7:0] ADDR_INSTR   = 8'd2;
    localparam logic [7:0] ADDR_MODE    = 8'd3;
    localparam logic [7:0] ADDR_CH_BASE = 8'd4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CONV,
        COMMIT
    } state_t;

    typedef logic [CH_WIDTH-1:0] ch_data_t;

endpackage

// File: rtl/readout_sequencer_if.sv
// Conversion handshake between the sequencer (master) and the PSEC5 digitizer
// front end (slave): one-cycle start request, channel select, done strobe and data.
interface readout_sequencer_if;
    import psec5_pkg::*;

    logic                conv_start;
    logic [CH_IDX_W-1:0] conv_ch;
    logic                conv_done;
    ch_data_t            conv_data;

    modport master (
        output conv_start,
        output conv_ch,
        input  conv_done,
        input  conv_data
    );

    modport slave (
        input  conv_start,
        input  conv_ch,
        output conv_done,
        output conv_data
    );

endinterface

// File: rtl/readout_sequencer_lowest_set.sv
// Combinational priority encoder: index of the lowest set bit of an 8-bit
// pending vector, plus a valid flag when any bit is set.
module lowest_set_8 (
    input  logic [7:0] pending_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx_o = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_i[i]) begin
                idx_o = 3'(i);
            end
        end
    end

    assign valid_o = |pending_i;

endmodule

// File: rtl/readout_sequencer.sv
// Sequences digitization of the enabled PSEC5 channels and commits the results
// to the ch0..ch7 buses only while the SPI slave is not reading channel data.
module readout_sequencer
    import psec5_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [7:0]                 trigger_channel_mask,
    input  logic [7:0]                 mode,
    input  logic                       sw_start,
    input  logic                       sw_abort,
    input  logic                       ext_trigger,
    input  logic                       spi_busy,
    readout_sequencer_if.master        conv_if,
    output ch_data_t                   ch0,
    output ch_data_t                   ch1,
    output ch_data_t                   ch2,
    output ch_data_t                   ch3,
    output ch_data_t                   ch4,
    output ch_data_t                   ch5,
    output ch_data_t                   ch6,
    output ch_data_t                   ch7,
    output logic                       data_ready,
    output logic                       busy,
    output logic [7:0]                 err_mask,
    output logic                       missed_trigger
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                             state_q, state_d;
    logic [NUM_CH-1:0]                  pending_q, pending_d;
    logic [NUM_CH-1:0]                  mask_q, mask_d;
    logic [CH_IDX_W-1:0]                idx_q, idx_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  stg_err_q, stg_err_d;
    logic [NUM_CH-1:0][CH_WIDTH-1:0]    staging_q;
    logic [NUM_CH-1:0][CH_WIDTH-1:0]    ch_q, ch_d;
    logic [NUM_CH-1:0]                  err_mask_q, err_mask_d;
    logic                               conv_start_q, conv_start_d;
    logic                               data_ready_q, data_ready_d;
    logic                               missed_q, missed_d;
    logic                               ext_prev_q;

    logic                               stg_we;
    ch_data_t                           stg_wdata;
    logic                               enc_valid;
    logic [CH_IDX_W-1:0]                enc_idx;
    logic                               start_evt;
    logic                               unused_mode;

    // Only the trigger-source bit changes behaviour; continuous mode re-arms by
    // simply returning to IDLE, which is what every run does anyway.
    assign unused_mode = ^mode[7:1];

    assign start_evt = mode[MODE_TRIG_SRC] ? (ext_trigger & ~ext_prev_q) : sw_start;

    lowest_set_8 u_lowest_set (
        .pending_i (pending_q),
        .valid_o   (enc_valid),
        .idx_o     (enc_idx)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        stg_err_d    = stg_err_q;
        ch_d         = ch_q;
        err_mask_d   = err_mask_q;
        missed_d     = missed_q;
        conv_start_d = 1'b0;
        data_ready_d = 1'b0;
        stg_we       = 1'b0;
        stg_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                if (start_evt && (trigger_channel_mask != 8'd0)) begin
                    pending_d = trigger_channel_mask;
                    mask_d    = trigger_channel_mask;
                    stg_err_d = '0;
                    missed_d  = 1'b0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (sw_abort) begin
                    state_d = IDLE;
                end else if (enc_valid) begin
                    idx_d        = enc_idx;
                    conv_start_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = CONV;
                end else begin
                    state_d = COMMIT;
                end
            end
            CONV: begin
                // Abort wins over done, and done wins over a timeout in the same cycle.
                if (sw_abort) begin
                    state_d = IDLE;
                end else if (conv_if.conv_done) begin
                    stg_we            = 1'b1;
                    stg_wdata         = conv_if.conv_data;
                    pending_d[idx_q]  = 1'b0;
                    state_d           = SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    stg_we            = 1'b1;
                    stg_err_d[idx_q]  = 1'b1;
                    pending_d[idx_q]  = 1'b0;
                    state_d           = SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                if (sw_abort) begin
                    state_d = IDLE;
                end else if (!spi_busy) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (mask_q[i]) begin
                            ch_d[i] = staging_q[i];
                        end
                    end
                    err_mask_d   = stg_err_q;
                    data_ready_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && start_evt) begin
            missed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            mask_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            stg_err_q    <= '0;
            ch_q         <= '0;
            err_mask_q   <= '0;
            conv_start_q <= 1'b0;
            data_ready_q <= 1'b0;
            missed_q     <= 1'b0;
            ext_prev_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            stg_err_q    <= stg_err_d;
            ch_q         <= ch_d;
            err_mask_q   <= err_mask_d;
            conv_start_q <= conv_start_d;
            data_ready_q <= data_ready_d;
            missed_q     <= missed_d;
            ext_prev_q   <= ext_trigger;
        end
    end

    // NOTE: staging data is not reset; every enabled channel is rewritten (data or zero) before it can be committed.
    always_ff @(posedge clk) begin
        if (stg_we) begin
            staging_q[idx_q] <= stg_wdata;
        end
    end

    assign conv_if.conv_start = conv_start_q;
    assign conv_if.conv_ch    = idx_q;

    assign ch0 = ch_q[0];
    assign ch1 = ch_q[1];
    assign ch2 = ch_q[2];
    assign ch3 = ch_q[3];
    assign ch4 = ch_q[4];
    assign ch5 = ch_q[5];
    assign ch6 = ch_q[6];
    assign ch7 = ch_q[7];

    assign data_ready     = data_ready_q;
    assign busy           = (state_q != IDLE);
    assign err_mask       = err_mask_q;
    assign missed_trigger = missed_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: directed vector table, hand-written
// latency/arbitration/abort/reset sequences and randomized runs against a run-level model.
module tb_readout_sequencer;
    import psec5_pkg::*;

    localparam int TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tcm = 8'd0;
    logic [7:0] mode = 8'd0;
    logic       sw_start = 1'b0;
    logic       sw_abort = 1'b0;
    logic       ext_trigger = 1'b0;
    logic       spi_busy = 1'b0;
    wire  [CH_WIDTH-1:0] ch_w [NUM_CH];
    logic       data_ready;
    logic       busy;
    logic [7:0] err_mask;
    logic       missed;

    readout_sequencer_if cif ();

    readout_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .trigger_channel_mask (tcm),
        .mode                 (mode),
        .sw_start             (sw_start),
        .sw_abort             (sw_abort),
        .ext_trigger          (ext_trigger),
        .spi_busy             (spi_busy),
        .conv_if              (cif),
        .ch0                  (ch_w[0]),
        .ch1                  (ch_w[1]),
        .ch2                  (ch_w[2]),
        .ch3                  (ch_w[3]),
        .ch4                  (ch_w[4]),
        .ch5                  (ch_w[5]),
        .ch6                  (ch_w[6]),
        .ch7                  (ch_w[7]),
        .data_ready           (data_ready),
        .busy                 (busy),
        .err_mask             (err_mask),
        .missed_trigger       (missed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Digitizer model: answers a conv_start after adc_lat[ch] negedges (0 = never answers).
    int       adc_lat [NUM_CH];
    ch_data_t adc_data [NUM_CH];
    int       adc_kill = 0;

    initial begin
        int cnt = 0;
        int ch = 0;
        int seen_kill = 0;
        cif.conv_done = 1'b0;
        cif.conv_data = '0;
        forever begin
            @(negedge clk);
            cif.conv_done = 1'b0;
            if (seen_kill != adc_kill) begin
                seen_kill = adc_kill;
                cnt = 0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    cif.conv_done = 1'b1;
                    cif.conv_data = adc_data[ch];
                end
            end
            if (cif.conv_start) begin
                ch  = int'(cif.conv_ch);
                cnt = adc_lat[ch];
            end
        end
    end

    // Passive monitor: append-only history of conversion requests and commit pulses.
    int rec[$];
    int dr_total = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cif.conv_start) rec.push_back(int'(cif.conv_ch));
            if (data_ready) dr_total++;
        end
    end

    // Run-level reference: what the channel buses and error mask should hold.
    ch_data_t   ch_model [NUM_CH];
    logic [7:0] err_model = 8'd0;

    task automatic model_run(input logic [7:0] m);
        logic [7:0] e;
        e = 8'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                if (adc_lat[i] == 0 || adc_lat[i] > TIMEOUT - 1) begin
                    ch_model[i] = '0;
                    e[i] = 1'b1;
                end else begin
                    ch_model[i] = adc_data[i];
                end
            end
        end
        err_model = e;
    endtask

    task automatic compare_model(input string tag);
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("%s ch%0d", tag, i), 64'(ch_w[i]), 64'(ch_model[i]));
        end
        check($sformatf("%s err_mask", tag), 64'(err_mask), 64'(err_model));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("%s ch%0d", tag, i), 64'(ch_w[i]), 64'd0);
        end
        check({tag, " err_mask"}, 64'(err_mask), 64'd0);
        check({tag, " data_ready"}, 64'(data_ready), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " missed"}, 64'(missed), 64'd0);
        check({tag, " conv_start"}, 64'(cif.conv_start), 64'd0);
        check({tag, " conv_ch"}, 64'(cif.conv_ch), 64'd0);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int k;
        k = 0;
        while (busy && k < max_cycles) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (busy) check({tag, " idle timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic pulse_sw_start();
        @(negedge clk);
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
    endtask

    // Software-started run; checks conversion order and commit count, then updates the model.
    task automatic do_run(input string tag, input logic [7:0] m);
        int r0;
        int d0;
        int k;
        r0 = rec.size();
        d0 = dr_total;
        tcm = m;
        pulse_sw_start();
        wait_idle(tag, 12000);
        check({tag, " conv count"}, 64'(rec.size() - r0), 64'($countones(m)));
        k = r0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i] && k < rec.size()) begin
                check($sformatf("%s conv order %0d", tag, k - r0), 64'(rec[k]), 64'(i));
                k++;
            end
        end
        check({tag, " data_ready pulses"}, 64'(dr_total - d0), (m != 8'd0) ? 64'd1 : 64'd0);
        if (m != 8'd0) model_run(m);
        compare_model(tag);
    endtask

    typedef struct {
        logic [7:0] mask;
        int         lat;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0;
        int d0;
        int k;
        ch_data_t old;

        for (int i = 0; i < NUM_CH; i++) begin
            adc_lat[i]  = 3;
            adc_data[i] = ch_data_t'(64'(i + 1) * 64'h0001_2345_6789_ABCD);
            ch_model[i] = '0;
        end
        adc_data[0] = 50'h2D2D2D2D2D2D3;
        adc_data[2] = 50'h0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        vecs[0] = '{8'h05, 3, 8'h00};
        vecs[1] = '{8'h80, 0, 8'h80};
        vecs[2] = '{8'hFF, 1, 8'h00};
        vecs[3] = '{8'h0A, 5, 8'h00};
        vecs[4] = '{8'h41, 0, 8'h41};
        vecs[5] = '{8'h00, 2, 8'h41};
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NUM_CH; i++) adc_lat[i] = vecs[v].lat;
            do_run($sformatf("vec%0d", v), vecs[v].mask);
            check($sformatf("vec%0d err_mask table", v), 64'(err_mask), 64'(vecs[v].exp_err));
        end

        // Latency: start sampled at edge N, conv_start after N+1; final done at M, commit at M+2.
        tcm = 8'h01;
        adc_lat[0] = 2;
        adc_data[0] = 50'h3_0F0F_1234_5678;
        @(negedge clk);
        sw_start = 1'b1;
        @(posedge clk);
        #2;
        check("lat busy after start", 64'(busy), 64'd1);
        check("lat conv_start early", 64'(cif.conv_start), 64'd0);
        @(negedge clk);
        sw_start = 1'b0;
        @(posedge clk);
        #2;
        check("lat conv_start", 64'(cif.conv_start), 64'd1);
        check("lat conv_ch", 64'(cif.conv_ch), 64'd0);
        k = 0;
        while (!cif.conv_done && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("lat conv_done seen", 64'(cif.conv_done), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("lat data_ready early", 64'(data_ready), 64'd0);
        @(posedge clk);
        #2;
        check("lat data_ready", 64'(data_ready), 64'd1);
        check("lat busy after commit", 64'(busy), 64'd0);
        model_run(8'h01);
        compare_model("lat");

        // SPI arbitration: commit held off while spi_busy, then taken in the first free cycle.
        tcm = 8'h02;
        adc_lat[1] = 3;
        adc_data[1] = 50'h1_5555_AAAA_5555;
        old = ch_w[1];
        d0 = dr_total;
        @(negedge clk);
        spi_busy = 1'b1;
        pulse_sw_start();
        repeat (20) @(posedge clk);
        #2;
        check("spi hold data_ready", 64'(dr_total - d0), 64'd0);
        check("spi hold ch1", 64'(ch_w[1]), 64'(old));
        check("spi hold busy", 64'(busy), 64'd1);
        @(negedge clk);
        spi_busy = 1'b0;
        @(posedge clk);
        #2;
        check("spi release data_ready", 64'(data_ready), 64'd1);
        check("spi release ch1", 64'(ch_w[1]), 64'(adc_data[1]));
        model_run(8'h02);
        compare_model("spi");

        // External trigger: one run per rising edge; an edge while busy is flagged.
        mode = 8'h01;
        tcm = 8'h03;
        adc_lat[0] = 4;
        adc_lat[1] = 4;
        r0 = rec.size();
        d0 = dr_total;
        @(negedge clk);
        ext_trigger = 1'b1;
        repeat (5) @(negedge clk);
        ext_trigger = 1'b0;
        repeat (2) @(negedge clk);
        ext_trigger = 1'b1;
        @(posedge clk);
        #2;
        check("ext busy at 2nd edge", 64'(busy), 64'd1);
        check("ext missed set", 64'(missed), 64'd1);
        wait_idle("ext", 200);
        check("ext one run", 64'(dr_total - d0), 64'd1);
        check("ext conv count", 64'(rec.size() - r0), 64'd2);
        check("ext missed sticky", 64'(missed), 64'd1);
        model_run(8'h03);
        @(negedge clk);
        ext_trigger = 1'b0;
        @(negedge clk);
        ext_trigger = 1'b1;
        @(posedge clk);
        #2;
        check("ext restart busy", 64'(busy), 64'd1);
        check("ext missed cleared", 64'(missed), 64'd0);
        @(negedge clk);
        ext_trigger = 1'b0;
        wait_idle("ext2", 200);
        model_run(8'h03);
        compare_model("ext");
        mode = 8'h00;

        // Abort during the conversion of ch3: nothing is committed.
        tcm = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            adc_lat[i] = 2;
            adc_data[i] = ch_data_t'({$urandom, $urandom});
        end
        adc_lat[3] = 0;
        d0 = dr_total;
        pulse_sw_start();
        k = 0;
        while (!(cif.conv_start && cif.conv_ch == 3'd3) && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("abort reached ch3", 64'(cif.conv_ch), 64'd3);
        repeat (3) @(negedge clk);
        sw_abort = 1'b1;
        @(posedge clk);
        #2;
        check("abort busy", 64'(busy), 64'd0);
        check("abort data_ready", 64'(data_ready), 64'd0);
        check("abort conv_start", 64'(cif.conv_start), 64'd0);
        @(negedge clk);
        sw_abort = 1'b0;
        adc_kill++;
        repeat (3) @(posedge clk);
        #2;
        check("abort no commit", 64'(dr_total - d0), 64'd0);
        compare_model("abort");

        // Randomized runs; ignored mode bits are randomized too.
        for (int n = 0; n < 20; n++) begin
            mode = {7'($urandom_range(0, 127)), 1'b0};
            for (int i = 0; i < NUM_CH; i++) begin
                adc_lat[i]  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
                adc_data[i] = ch_data_t'({$urandom, $urandom});
            end
            do_run($sformatf("rand%0d", n), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
        end
        mode = 8'h00;

        // Reset mid-CONV clears everything; a later zero-mask start is ignored.
        tcm = 8'h10;
        adc_lat[4] = 0;
        pulse_sw_start();
        repeat (5) @(posedge clk);
        pulse_sw_start();
        #2;
        check("rst missed before reset", 64'(missed), 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        adc_kill++;
        check_reset_outputs("midrun reset");
        for (int i = 0; i < NUM_CH; i++) ch_model[i] = '0;
        err_model = 8'd0;
        d0 = dr_total;
        tcm = 8'h00;
        pulse_sw_start();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            check($sformatf("zero mask busy %0d", c), 64'(busy), 64'd0);
        end
        check("zero mask no commit", 64'(dr_total - d0), 64'd0);
        compare_model("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
